jellyvl_etherneco_synctimer_scheduler: RTL
==========================================

Name: jellyvl_etherneco_synctimer_scheduler

Overview:
Master-side scheduler that sequences periodic sync-timer command frames onto the EtherNeco ring. It compares the local timer against a programmed deadline and requests a sync frame from the ring transmitter. It then waits for the returning response, retrying on error or timeout, and advances the deadline one period per frame. It sits between the synctimer timer (current_time) and the ring command transmitter/response receiver.

Parameters:
TIMER_WIDTH, 64, width of current_time and deadline
PERIOD_WIDTH, 32, width of sync period (timer units)
TIMEOUT_WIDTH, 16, width of response-timeout counter (clk cycles)
RETRY_WIDTH, 4, width of retry limit/counter
SYNC_TYPE, 8'h10, frame type code issued and expected back

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
enable  in  1  scheduler run; low drains to IDLE
current_time  in  TIMER_WIDTH  local timer value
param_start  in  TIMER_WIDTH  first deadline, latched on IDLE->WAIT
param_period  in  PERIOD_WIDTH  sync period; 0 is treated as 1
param_timeout  in  TIMEOUT_WIDTH  response timeout in cycles
param_max_retry  in  RETRY_WIDTH  retries after first attempt
m_req_valid  out  1  frame request
m_req_ready  in  1  transmitter accepts
m_req_type  out  8  = SYNC_TYPE
m_req_seq  out  8  frame sequence number
m_req_time  out  TIMER_WIDTH  deadline carried in frame
res_rx_end  in  1  response frame finished (1-cycle pulse)
res_rx_error  in  1  response frame error, qualified by res_rx_end
res_rx_type  in  8  response type, qualified by res_rx_end
busy  out  1  state != IDLE
done_pulse  out  1  1-cycle pulse on successful response
fail_pulse  out  1  1-cycle pulse on retries exhausted

Behaviour:
- Reset values: m_req_valid=0, m_req_seq=0, m_req_time=0, busy=0, done_pulse=0, fail_pulse=0, state=IDLE, retry count=0.
- States: IDLE, WAIT, REQ, RESP.
- IDLE: when enable=1, next cycle latch deadline=param_start and go to WAIT.
- WAIT: diff = signed(current_time - deadline), full TIMER_WIDTH with wrap.
  - diff >= 0: go to REQ.
  - diff >= period: deadline behind by at least one period. Add period once per cycle and stay in WAIT; no frame is issued for a skipped slot.
- REQ: m_req_valid=1 with type/seq/time stable until m_req_ready. On the handshake cycle go to RESP and load the timeout counter with param_timeout.
- RESP: decrement the counter each cycle.
  - res_rx_end & !res_rx_error & res_rx_type==SYNC_TYPE: done_pulse; seq+=1; deadline+=period; retry=0; go to WAIT.
  - res_rx_end with an error or a mismatched type: treat as failure.
  - Counter reaching 0 without res_rx_end: treat as failure.
  - Failure with retry < param_max_retry: retry+=1, back to REQ. seq and time are unchanged; the same frame is re-sent.
  - Failure otherwise: fail_pulse; seq+=1; deadline+=period; retry=0; go to WAIT.
- Simultaneous events: if res_rx_end arrives in the same cycle the counter hits 0, the response wins.
- Outside RESP: res_rx_end is ignored.
- enable=0: WAIT and RESP go to IDLE next cycle. REQ holds until its handshake completes, then goes to IDLE; a valid is never withdrawn.
- Latency: WAIT->REQ takes 1 cycle after the deadline is reached. m_req_valid is registered.
- seq wraps 255->0. param_timeout=0 is treated as 1.

Optional Feature:
JELLYVL_SYNCTIMER_SCHED_STATS_EN
- Defined: adds outputs stat_done, stat_fail, stat_skip, stat_retry (32 bit each). They are saturating counters, cleared by reset and by the IDLE->WAIT transition.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package jellyvl_etherneco_synctimer_pkg holds:
  - state enum type;
  - frame type constants (SYNC_TYPE default);
  - t_time/t_period typedefs.
- Sub-module jellyvl_etherneco_synctimer_deadline owns the deadline register, wrap-safe signed compare and period advance. Its outputs are reached and behind, and it takes load/advance strobes.

Test Plan:
- Nominal: period=1000, start=500, ready tied 1, response 20 cycles after request. Requests at current_time 500, 1500, 2500; seq 0,1,2; three done_pulse.
- Timeout retry: timeout=50, max_retry=2, no responses. REQ issued 3 times with the same seq/time, one fail_pulse, next request at deadline+period with seq+1.
- Error then success: first response has res_rx_error=1, second is clean. One retry, done_pulse, no fail_pulse.
- Skip: deadline=500, current_time jumps to 3700 with period=1000. Deadline advances to 3500 without requests, then 1 request with m_req_time=3500.
- Backpressure/disable: m_req_ready=0 for 10 cycles, enable dropped in cycle 3. m_req_valid and payload stay stable until ready, then the scheduler reaches IDLE and busy=0.
- Reset mid-RESP: assert reset asynchronously. All outputs go to their reset values immediately, with no pulse on release.

Source files
------------

// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// ---------------------------------------------------------------------------
// jellyvl_etherneco_synctimer_pkg
//
// Shared definitions for the EtherNeco sync-timer scheduler slice:
//   - t_state         : scheduler FSM state encoding
//   - FRAME_TYPE_SYNC : frame type code used for sync command frames
//   - t_time/t_period : default-width timer and period types
//   - sat_inc32       : saturating 32-bit increment used by the statistics
// ---------------------------------------------------------------------------
package jellyvl_etherneco_synctimer_pkg;

  localparam int unsigned DEFAULT_TIMER_WIDTH  = 64;
  localparam int unsigned DEFAULT_PERIOD_WIDTH = 32;

  localparam logic [7:0] FRAME_TYPE_SYNC = 8'h10;

  typedef logic [DEFAULT_TIMER_WIDTH-1:0]  t_time;
  typedef logic [DEFAULT_PERIOD_WIDTH-1:0] t_period;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_REQ  = 2'd2,
    ST_RESP = 2'd3
  } t_state;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/jellyvl_etherneco_synctimer_deadline.sv
// ---------------------------------------------------------------------------
// jellyvl_etherneco_synctimer_deadline
//
// Holds the next sync deadline and compares it against the local timer.
// The compare is done on the wrapped difference (current_time - deadline)
// interpreted as signed, so the scheduler keeps working across timer wrap.
//
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   load, load_value : overwrite the deadline (takes priority over advance)
//   advance, period  : add one period to the deadline
//   current_time     : local timer value
//   deadline         : current deadline register
//   reached          : current_time is at or past the deadline
//   behind           : current_time is at least one full period past it
// ---------------------------------------------------------------------------
module jellyvl_etherneco_synctimer_deadline #(
  parameter int unsigned TIMER_WIDTH  = 64,
  parameter int unsigned PERIOD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [TIMER_WIDTH-1:0]  load_value,
  input  logic                    advance,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [TIMER_WIDTH-1:0]  current_time,
  output logic [TIMER_WIDTH-1:0]  deadline,
  output logic                    reached,
  output logic                    behind
);

  logic [TIMER_WIDTH-1:0] deadline_q;
  logic [TIMER_WIDTH-1:0] deadline_d;
  logic [TIMER_WIDTH-1:0] diff;
  logic [TIMER_WIDTH-1:0] period_ext;

  assign period_ext = TIMER_WIDTH'(period);
  assign diff       = current_time - deadline_q;

  // A clear sign bit means the deadline has been reached. Once that holds,
  // diff is a plain non-negative magnitude and can be compared unsigned.
  assign reached  = ~diff[TIMER_WIDTH-1];
  assign behind   = reached && (diff >= period_ext);
  assign deadline = deadline_q;

  // Next deadline: a fresh load wins over a period advance.
  always_comb begin
    deadline_d = deadline_q;
    if (load) begin
      deadline_d = load_value;
    end else if (advance) begin
      deadline_d = deadline_q + period_ext;
    end
  end

  // Deadline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deadline_q <= '0;
    end else begin
      deadline_q <= deadline_d;
    end
  end

endmodule

// File: rtl/jellyvl_etherneco_synctimer_scheduler.sv
// ---------------------------------------------------------------------------
// jellyvl_etherneco_synctimer_scheduler
//
// Master-side scheduler issuing periodic sync command frames on the
// EtherNeco ring. It waits for the local timer to reach the deadline and
// requests a frame. Then it waits for the matching response, retrying on
// error/timeout, and moves the deadline on by one period per frame.
//
// Optional statistics: define JELLYVL_SYNCTIMER_SCHED_STATS_EN to add the
// saturating counters stat_done/stat_fail/stat_skip/stat_retry.
//
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   enable               : run; low drains the scheduler back to IDLE
//   current_time         : local timer
//   param_*              : start deadline, period, response timeout, retries
//   m_req_*              : frame request to the ring transmitter
//   res_rx_*             : response frame status from the ring receiver
//   busy                 : scheduler not idle
//   done_pulse/fail_pulse: one-cycle result strobes per frame
// ---------------------------------------------------------------------------
module jellyvl_etherneco_synctimer_scheduler
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH   = 64,
  parameter int unsigned PERIOD_WIDTH  = 32,
  parameter int unsigned TIMEOUT_WIDTH = 16,
  parameter int unsigned RETRY_WIDTH   = 4,
  parameter logic [7:0]  SYNC_TYPE     = FRAME_TYPE_SYNC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [TIMER_WIDTH-1:0]   current_time,
  input  logic [TIMER_WIDTH-1:0]   param_start,
  input  logic [PERIOD_WIDTH-1:0]  param_period,
  input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
  input  logic [RETRY_WIDTH-1:0]   param_max_retry,
  output logic                     m_req_valid,
  input  logic                     m_req_ready,
  output logic [7:0]               m_req_type,
  output logic [7:0]               m_req_seq,
  output logic [TIMER_WIDTH-1:0]   m_req_time,
  input  logic                     res_rx_end,
  input  logic                     res_rx_error,
  input  logic [7:0]               res_rx_type,
  output logic                     busy,
  output logic                     done_pulse,
  output logic                     fail_pulse
`ifdef JELLYVL_SYNCTIMER_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_done,
  output logic [31:0]              stat_fail,
  output logic [31:0]              stat_skip,
  output logic [31:0]              stat_retry
`endif
);

  t_state                   state_q,    state_d;
  logic [RETRY_WIDTH-1:0]   retry_q,    retry_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q,      tmo_d;
  logic [7:0]               seq_q,      seq_d;
  logic [TIMER_WIDTH-1:0]   req_time_q, req_time_d;
  logic                     valid_q,    valid_d;
  logic                     done_q,     done_d;
  logic                     fail_q,     fail_d;

  logic                     dl_load;
  logic                     dl_advance;
  logic [TIMER_WIDTH-1:0]   deadline;
  logic                     reached;
  logic                     behind;

  logic [PERIOD_WIDTH-1:0]  period_eff;
  logic [TIMEOUT_WIDTH-1:0] timeout_eff;
  logic                     handshake;
  logic                     resp_ok;
  logic                     failure;

  // Zero period or timeout would stall the scheduler, so both clamp to 1.
  assign period_eff  = (param_period  == '0) ? PERIOD_WIDTH'(1)  : param_period;
  assign timeout_eff = (param_timeout == '0) ? TIMEOUT_WIDTH'(1) : param_timeout;

  assign handshake = valid_q & m_req_ready;
  assign resp_ok   = res_rx_end & ~res_rx_error & (res_rx_type == SYNC_TYPE);

  // Any bad response fails the attempt. Without a response, the attempt
  // fails when the counter hits zero. A response in that same cycle wins.
  assign failure = res_rx_end ? ~resp_ok : (tmo_q <= TIMEOUT_WIDTH'(1));

  jellyvl_etherneco_synctimer_deadline #(
    .TIMER_WIDTH  (TIMER_WIDTH),
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_deadline (
    .clk          (clk),
    .reset        (reset),
    .load         (dl_load),
    .load_value   (param_start),
    .advance      (dl_advance),
    .period       (period_eff),
    .current_time (current_time),
    .deadline     (deadline),
    .reached      (reached),
    .behind       (behind)
  );

  // Scheduler FSM. REQ ignores enable until its handshake completes, so an
  // offered request is never withdrawn. Skipped slots only move the
  // deadline, one period per cycle, and never produce a frame.
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    seq_d      = seq_q;
    req_time_d = req_time_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    dl_load    = 1'b0;
    dl_advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          dl_load = 1'b1;
          retry_d = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (behind) begin
          dl_advance = 1'b1;
        end else if (reached) begin
          valid_d    = 1'b1;
          req_time_d = deadline;
          state_d    = ST_REQ;
        end
      end

      ST_REQ: begin
        if (handshake) begin
          valid_d = 1'b0;
          tmo_d   = timeout_eff;
          if (enable) begin
            state_d = ST_RESP;
          end else begin
            retry_d = '0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_RESP: begin
        if (!enable) begin
          retry_d = '0;
          state_d = ST_IDLE;
        end else if (resp_ok) begin
          done_d     = 1'b1;
          seq_d      = seq_q + 8'd1;
          dl_advance = 1'b1;
          retry_d    = '0;
          state_d    = ST_WAIT;
        end else if (failure) begin
          if (retry_q < param_max_retry) begin
            // Re-send the identical frame: seq and time are left alone.
            retry_d = retry_q + RETRY_WIDTH'(1);
            valid_d = 1'b1;
            state_d = ST_REQ;
          end else begin
            fail_d     = 1'b1;
            seq_d      = seq_q + 8'd1;
            dl_advance = 1'b1;
            retry_d    = '0;
            state_d    = ST_WAIT;
          end
        end else begin
          tmo_d = tmo_q - TIMEOUT_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      retry_q    <= '0;
      tmo_q      <= '0;
      seq_q      <= '0;
      req_time_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      seq_q      <= seq_d;
      req_time_q <= req_time_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign m_req_valid = valid_q;
  assign m_req_type  = SYNC_TYPE;
  assign m_req_seq   = seq_q;
  assign m_req_time  = req_time_q;
  assign busy        = (state_q != ST_IDLE);
  assign done_pulse  = done_q;
  assign fail_pulse  = fail_q;

`ifdef JELLYVL_SYNCTIMER_SCHED_STATS_EN
  logic [31:0] stat_done_q;
  logic [31:0] stat_fail_q;
  logic [31:0] stat_skip_q;
  logic [31:0] stat_retry_q;
  logic        skip_evt;
  logic        retry_evt;

  assign skip_evt  = (state_q == ST_WAIT) & enable & behind;
  assign retry_evt = (state_q == ST_RESP) & enable & ~resp_ok & failure &
                     (retry_q < param_max_retry);

  // Statistics restart with every new run (IDLE->WAIT).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_done_q  <= '0;
      stat_fail_q  <= '0;
      stat_skip_q  <= '0;
      stat_retry_q <= '0;
    end else if (dl_load) begin
      stat_done_q  <= '0;
      stat_fail_q  <= '0;
      stat_skip_q  <= '0;
      stat_retry_q <= '0;
    end else begin
      if (done_d)    stat_done_q  <= sat_inc32(stat_done_q);
      if (fail_d)    stat_fail_q  <= sat_inc32(stat_fail_q);
      if (skip_evt)  stat_skip_q  <= sat_inc32(stat_skip_q);
      if (retry_evt) stat_retry_q <= sat_inc32(stat_retry_q);
    end
  end

  assign stat_done  = stat_done_q;
  assign stat_fail  = stat_fail_q;
  assign stat_skip  = stat_skip_q;
  assign stat_retry = stat_retry_q;
`endif

endmodule
